// File: rtl/uab_pio_pkg.sv
// Shared definitions for the UAB PIO blocks (key input port and LED output port):
// register offsets, Avalon data width and the polarity-dependent idle level.
package uab_pio_pkg;

  localparam int unsigned BUS_WIDTH = 32;

  typedef enum logic [1:0] {
    REG_DATA    = 2'd0,
    REG_RSVD    = 2'd1,
    REG_IRQMASK = 2'd2,
    REG_EDGECAP = 2'd3
  } reg_offset_e;

  // Idle level of a released input: active-low keys idle high.
  function automatic logic [BUS_WIDTH-1:0] stable_reset_value(input logic capture_falling);
    return {BUS_WIDTH{capture_falling}};
  endfunction

endpackage

// File: rtl/uab_key_pio_in_if.sv
// Avalon-MM responder bus of the key input port; the CPU side is the master.
interface uab_key_pio_in_if;
  import uab_pio_pkg::*;

  logic [1:0]           address;
  logic                 read;
  logic                 write;
  logic [BUS_WIDTH-1:0] writedata;
  logic [BUS_WIDTH-1:0] readdata;

  modport master (output address, output read, output write, output writedata,
                  input  readdata);

  modport slave  (input  address, input  read, input  write, input  writedata,
                  output readdata);

endinterface

// File: rtl/uab_debounce.sv
// One-bit debouncer: stable only follows the synchronised input once it has
// differed for DEBOUNCE_CYCLES consecutive cycles (used when UAB_KEY_DEBOUNCE_EN is defined).
module uab_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter logic        RESET_VALUE     = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sync_in,
  output logic stable
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] count;

  // Any sample agreeing with stable restarts the window, so short glitches never land.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count  <= '0;
      stable <= RESET_VALUE;
    end else if (sync_in == stable) begin
      count <= '0;
    end else if (count == CNT_LAST) begin
      stable <= sync_in;
      count  <= '0;
    end else begin
      count <= count + CNT_W'(1);
    end
  end

endmodule

// File: rtl/uab_key_pio_in.sv
// Key/switch input PIO: synchronise, debounce, capture edges, level irq.
// Macro UAB_KEY_DEBOUNCE_EN selects the debouncer; undefined, stable is the synchroniser output registered once.
module uab_key_pio_in
  import uab_pio_pkg::*;
#(
  parameter int unsigned WIDTH           = 8,
  parameter int unsigned DEBOUNCE_CYCLES = 50000,
  parameter int unsigned CAPTURE_FALLING = 1
) (
  input  logic             clk_clk,
  input  logic             reset_reset_n,
  uab_key_pio_in_if.slave  avs,
  input  logic [WIDTH-1:0] keys_export,
  output logic             irq
);

  localparam logic [BUS_WIDTH-1:0] RST_FULL = stable_reset_value(CAPTURE_FALLING != 0);
  localparam logic [WIDTH-1:0]     RST_VAL  = RST_FULL[WIDTH-1:0];

  logic [WIDTH-1:0]     sync_meta;
  logic [WIDTH-1:0]     sync_out;
  logic [1:0]           warm;
  logic [WIDTH-1:0]     stable;
  logic [WIDTH-1:0]     stable_d;
  logic [WIDTH-1:0]     armed;
  logic [WIDTH-1:0]     irq_mask;
  logic [WIDTH-1:0]     edgecap;
  logic [WIDTH-1:0]     edge_hit;
  logic [WIDTH-1:0]     clear_bits;
  logic                 mask_we;
  logic                 edgecap_we;
  logic [BUS_WIDTH-1:0] rd_mux;

  // warm marks when sync_out carries real pin samples rather than reset values.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      sync_meta <= RST_VAL;
      sync_out  <= RST_VAL;
      warm      <= 2'b00;
    end else begin
      sync_meta <= keys_export;
      sync_out  <= sync_meta;
      warm      <= {warm[0], 1'b1};
    end
  end

`ifdef UAB_KEY_DEBOUNCE_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_debounce
    uab_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_VALUE     (RST_VAL[i])
    ) u_debounce (
      .clk     (clk_clk),
      .rst_n   (reset_reset_n),
      .sync_in (sync_out[i]),
      .stable  (stable[i])
    );
  end
`else
  wire unused_debounce_cfg = (DEBOUNCE_CYCLES > 1);

  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable <= RST_VAL;
    end else begin
      stable <= sync_out;
    end
  end
`endif

  if (WIDTH < BUS_WIDTH) begin : g_unused_wdata
    wire unused_wdata = ^avs.writedata[BUS_WIDTH-1:WIDTH];
  end

  // A bit only captures edges once a real sample has agreed with stable, so
  // the first acquisition after reset of a pin held away from idle is silent.
  always_comb begin
    edge_hit = '0;
    if (CAPTURE_FALLING != 0) begin
      edge_hit = stable_d & ~stable & armed;
    end else begin
      edge_hit = stable & ~stable_d & armed;
    end
  end

  always_comb begin
    mask_we    = avs.write && (avs.address == REG_IRQMASK);
    edgecap_we = avs.write && (avs.address == REG_EDGECAP);
    clear_bits = edgecap_we ? avs.writedata[WIDTH-1:0] : '0;
  end

  // New edges are OR-ed in after the clear so a colliding W1C loses.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      stable_d <= RST_VAL;
      armed    <= '0;
      irq_mask <= '0;
      edgecap  <= '0;
    end else begin
      stable_d <= stable;
      armed    <= armed | ({WIDTH{warm[1]}} & ~(sync_out ^ stable));
      edgecap  <= (edgecap & ~clear_bits) | edge_hit;
      if (mask_we) begin
        irq_mask <= avs.writedata[WIDTH-1:0];
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (avs.address)
      REG_DATA:    rd_mux[WIDTH-1:0] = stable;
      REG_RSVD:    rd_mux = '0;
      REG_IRQMASK: rd_mux[WIDTH-1:0] = irq_mask;
      REG_EDGECAP: rd_mux[WIDTH-1:0] = edgecap;
    endcase
  end

  // Read data is captured from pre-edge register values and held until the next read.
  always_ff @(posedge clk_clk or negedge reset_reset_n) begin
    if (!reset_reset_n) begin
      avs.readdata <= '0;
    end else if (avs.read) begin
      avs.readdata <= rd_mux;
    end
  end

  assign irq = |(edgecap & irq_mask);

endmodule

// File: tb/tb_uab_key_pio_in.sv
// Self-checking bench for uab_key_pio_in: directed scenarios plus random traffic
// compared every cycle against a sample-history reference model.
module tb_uab_key_pio_in;
  import uab_pio_pkg::*;

  localparam int unsigned WIDTH = 8;
  localparam int unsigned DC    = 4;
  localparam int unsigned CF    = 1;
`ifdef UAB_KEY_DEBOUNCE_EN
  localparam int DATA_LAT = DC + 2;
  localparam logic [7:0] GLITCH_EC = 8'h04;
`else
  localparam int DATA_LAT = 3;
  localparam logic [7:0] GLITCH_EC = 8'h05;
`endif

  logic       clk_clk = 1'b0;
  logic       reset_reset_n = 1'b1;
  logic [7:0] keys_export = 8'hFF;
  logic       irq;
  logic       check_en = 1'b0;

  int tests_run = 0;
  int tests_failed = 0;

  uab_key_pio_in_if avs ();

  uab_key_pio_in #(
    .WIDTH           (WIDTH),
    .DEBOUNCE_CYCLES (DC),
    .CAPTURE_FALLING (CF)
  ) dut (
    .clk_clk       (clk_clk),
    .reset_reset_n (reset_reset_n),
    .avs           (avs),
    .keys_export   (keys_export),
    .irq           (irq)
  );

  always #5 clk_clk = ~clk_clk;

  // Reference model: pin samples kept as a history; a bit's level is accepted
  // when the last DC synchronised samples all disagree with the current level.
  logic [7:0]  hist [0:DC+1];
  logic [7:0]  m_stable, m_stable_d, m_edgecap, m_mask, m_armed;
  logic [31:0] m_rdata;
  int          m_edges;
  logic        m_irq;

  assign m_irq = |(m_edgecap & m_mask);

  always @(posedge clk_clk or negedge reset_reset_n) begin : model
    logic [7:0] fall, clr, nxt, seen, new_ec;
    bit differ;
    if (!reset_reset_n) begin
      for (int i = 0; i <= DC + 1; i++) hist[i] = 8'hFF;
      m_stable   = 8'hFF;
      m_stable_d = 8'hFF;
      m_edgecap  = 8'h00;
      m_mask     = 8'h00;
      m_armed    = 8'h00;
      m_rdata    = 32'h0;
      m_edges    = 0;
    end else begin
      m_edges = m_edges + 1;
      if (avs.read) begin
        case (avs.address)
          2'd0:    m_rdata = 32'(m_stable);
          2'd2:    m_rdata = 32'(m_mask);
          2'd3:    m_rdata = 32'(m_edgecap);
          default: m_rdata = 32'h0;
        endcase
      end
      fall   = m_stable_d & ~m_stable & m_armed;
      clr    = (avs.write && avs.address == 2'd3) ? avs.writedata[7:0] : 8'h00;
      new_ec = (m_edgecap & ~clr) | fall;
      if (avs.write && avs.address == 2'd2) m_mask = avs.writedata[7:0];
      for (int i = DC + 1; i >= 1; i--) hist[i] = hist[i-1];
      hist[0] = keys_export;
      seen = hist[2];
      if (m_edges >= 3) m_armed = m_armed | ~(seen ^ m_stable);
      nxt = m_stable;
`ifdef UAB_KEY_DEBOUNCE_EN
      for (int b = 0; b < 8; b++) begin
        differ = 1'b1;
        for (int k = 2; k <= DC + 1; k++) begin
          if (hist[k][b] == m_stable[b]) differ = 1'b0;
        end
        if (differ) nxt[b] = ~m_stable[b];
      end
`else
      nxt = seen;
`endif
      m_stable_d = m_stable;
      m_stable   = nxt;
      m_edgecap  = new_ec;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk_clk) begin
    if (check_en) begin
      checkOutput("irq_model", 32'(irq), 32'(m_irq));
      checkOutput("rdata_model", avs.readdata, m_rdata);
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk_clk);
  endtask

  task automatic busWrite(input logic [1:0] a, input logic [31:0] d);
    avs.address   = a;
    avs.writedata = d;
    avs.write     = 1'b1;
    @(negedge clk_clk);
    avs.write     = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] a, output logic [31:0] d);
    avs.address = a;
    avs.read    = 1'b1;
    @(negedge clk_clk);
    avs.read    = 1'b0;
    d = avs.readdata;
  endtask

  task automatic applyStimulus(input int cycles);
    int op;
    for (int c = 0; c < cycles; c++) begin
      if ($urandom_range(0, 5) == 0) keys_export = keys_export ^ 8'(1 << $urandom_range(0, 7));
      op = $urandom_range(0, 3);
      avs.address   = 2'($urandom_range(0, 3));
      avs.writedata = $urandom;
      avs.read      = (op == 1);
      avs.write     = (op == 2);
      @(negedge clk_clk);
    end
    avs.read  = 1'b0;
    avs.write = 1'b0;
  endtask

  logic [31:0] rd;

  initial begin
    avs.address   = 2'd0;
    avs.read      = 1'b0;
    avs.write     = 1'b0;
    avs.writedata = 32'h0;
    #2 reset_reset_n = 1'b0;
    check_en = 1'b1;
    idle(3);
    #2 reset_reset_n = 1'b1;
    idle(1);

    $display("[TB] reset state");
    checkOutput("irq_reset", 32'(irq), 32'h0);
    busRead(2'd0, rd); checkOutput("reset_data", rd, 32'h000000FF);
    busRead(2'd1, rd); checkOutput("reset_rsvd", rd, 32'h0);
    busRead(2'd2, rd); checkOutput("reset_mask", rd, 32'h0);
    busRead(2'd3, rd); checkOutput("reset_edgecap", rd, 32'h0);

    $display("[TB] clean press");
    keys_export[2] = 1'b0;
    idle(DATA_LAT - 1);
    busRead(2'd0, rd); checkOutput("press_before", rd, 32'h000000FF);
    busRead(2'd0, rd); checkOutput("press_data", rd, 32'h000000FB);
    busRead(2'd3, rd); checkOutput("press_edgecap", rd, 32'h00000004);
    checkOutput("press_irq_masked", 32'(irq), 32'h0);

    $display("[TB] glitch");
    keys_export[0] = 1'b0;
    idle(3);
    keys_export[0] = 1'b1;
    idle(DATA_LAT + 3);
    busRead(2'd0, rd); checkOutput("glitch_data", rd, 32'h000000FB);
    busRead(2'd3, rd); checkOutput("glitch_edgecap", rd, 32'(GLITCH_EC));

    $display("[TB] interrupt and clear");
    busWrite(2'd2, 32'hFFFF_FF04);
    checkOutput("irq_set", 32'(irq), 32'h1);
    busRead(2'd2, rd); checkOutput("mask_read", rd, 32'h00000004);
    busWrite(2'd3, 32'h0000_0005);
    checkOutput("irq_clear", 32'(irq), 32'h0);
    busRead(2'd3, rd); checkOutput("edgecap_cleared", rd, 32'h0);
    busWrite(2'd0, 32'h0);
    busRead(2'd0, rd); checkOutput("data_ro", rd, 32'h000000FB);

    $display("[TB] set/clear collision");
    busWrite(2'd2, 32'h0000_0024);
    keys_export[5] = 1'b0;
    idle(DATA_LAT);
    busWrite(2'd3, 32'h0000_0020);
    checkOutput("collide_irq", 32'(irq), 32'h1);
    busRead(2'd3, rd); checkOutput("collide_edgecap", rd, 32'h00000020);

    $display("[TB] reset mid-debounce");
    keys_export[7] = 1'b0;
    idle(2);
    #2 reset_reset_n = 1'b0;
    idle(2);
    #2 reset_reset_n = 1'b1;
    idle(DATA_LAT - 1);
    busRead(2'd0, rd); checkOutput("rst_data_before", rd, 32'h000000FF);
    busRead(2'd0, rd); checkOutput("rst_data_after", rd, 32'h0000005B);
    idle(3);
    busRead(2'd3, rd); checkOutput("rst_edgecap", rd, 32'h0);
    checkOutput("rst_irq", 32'(irq), 32'h0);
    keys_export[2] = 1'b1;
    idle(DATA_LAT + 2);
    keys_export[2] = 1'b0;
    idle(DATA_LAT + 2);
    busRead(2'd3, rd); checkOutput("rearm_edgecap", rd, 32'h00000004);

    $display("[TB] random traffic");
    applyStimulus(3000);
    idle(DATA_LAT + 4);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
